// File: rtl/oam_dma_controller_if.sv
// Register bus ($FF46) and DMA master bus between the OAM DMA engine and the MMU.
// master = DMA engine side, slave = MMU side.
interface oam_dma_controller_if;
  logic [15:0] reg_addr;
  logic        reg_read_en;
  logic        reg_write_en;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_read_en;
  logic        dma_write_en;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_rdata;

  modport master (
    input  reg_addr, reg_read_en, reg_write_en, reg_wdata, dma_rdata,
    output reg_rdata, dma_active, dma_addr, dma_read_en, dma_write_en, dma_wdata
  );

  modport slave (
    output reg_addr, reg_read_en, reg_write_en, reg_wdata, dma_rdata,
    input  reg_rdata, dma_active, dma_addr, dma_read_en, dma_write_en, dma_wdata
  );
endinterface

// File: rtl/oam_dma_controller.sv
// OAM DMA engine behind $FF46: copies NUM_BYTES source bytes to $FE00.., one byte per CYCLES_PER_BYTE slot.
// First source read START_DELAY clocks after the write; no backpressure, register writes always accepted and restart.
module oam_dma_controller #(
  parameter int NUM_BYTES       = 160,
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  oam_dma_controller_if.master bus
);
  localparam int DW = (START_DELAY > 2) ? $clog2(START_DELAY) : 1;
  localparam int SW = $clog2(CYCLES_PER_BYTE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_READ,
    S_WRITE,
    S_WAIT
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    src_hi, src_hi_nxt;
  logic [DW-1:0] dly, dly_nxt;
  logic [7:0]    idx, idx_nxt;
  logic [SW-1:0] slot, slot_nxt;
  logic [7:0]    byte_q, byte_nxt;
  logic          hold_q, hold_nxt;

  logic          reg_wr;
  logic          slot_end;
  logic          last_byte;
  logic [7:0]    base_hi;
  logic [15:0]   src_addr;
  logic [15:0]   oam_addr;

  logic          act;
  logic          rd_en;
  logic          wr_en;
  logic [15:0]   addr;
  logic [7:0]    wdata;

  logic          unused_ok;
  assign unused_ok = bus.reg_read_en;

  assign reg_wr    = bus.reg_write_en && (bus.reg_addr == 16'hFF46);
  // slot counts clocks within a byte slot: READ=0, WRITE=1, WAIT=2..CYCLES_PER_BYTE-1
  assign slot_end  = (slot == SW'(CYCLES_PER_BYTE - 1));
  assign last_byte = (idx == 8'(NUM_BYTES - 1));
  // Echo RAM sources ($E000+) fold back onto WRAM
  assign base_hi   = (src_hi < 8'hE0) ? src_hi : (src_hi - 8'h20);
  assign src_addr  = {base_hi, 8'h00} + {8'h00, idx};
  assign oam_addr  = 16'hFE00 + {8'h00, idx};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      src_hi <= 8'hFF;
      dly    <= '0;
      idx    <= '0;
      slot   <= '0;
      byte_q <= '0;
      hold_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      src_hi <= src_hi_nxt;
      dly    <= dly_nxt;
      idx    <= idx_nxt;
      slot   <= slot_nxt;
      byte_q <= byte_nxt;
      hold_q <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    src_hi_nxt = src_hi;
    dly_nxt    = dly;
    idx_nxt    = idx;
    slot_nxt   = slot;
    byte_nxt   = byte_q;
    hold_nxt   = hold_q;
    act        = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    addr       = 16'h0000;
    wdata      = 8'h00;

    case (state)
      S_IDLE: begin
      end
      S_START: begin
        act = hold_q;
        if (dly == '0) begin
          state_nxt = S_READ;
          idx_nxt   = '0;
          slot_nxt  = '0;
          hold_nxt  = 1'b0;
        end else begin
          dly_nxt = dly - DW'(1);
        end
      end
      S_READ: begin
        act       = 1'b1;
        rd_en     = 1'b1;
        addr      = src_addr;
        byte_nxt  = bus.dma_rdata;
        slot_nxt  = slot + SW'(1);
        state_nxt = S_WRITE;
      end
      S_WRITE, S_WAIT: begin
        act   = 1'b1;
        addr  = oam_addr;
        wr_en = (state == S_WRITE);
        wdata = (state == S_WRITE) ? byte_q : 8'h00;
        if (!slot_end) begin
          slot_nxt  = slot + SW'(1);
          state_nxt = S_WAIT;
        end else if (last_byte) begin
          state_nxt = S_IDLE;
        end else begin
          idx_nxt   = idx + 8'd1;
          slot_nxt  = '0;
          state_nxt = S_READ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // A write always wins, including over the final slot end; bus ownership is kept across a restart
    if (reg_wr) begin
      src_hi_nxt = bus.reg_wdata;
      state_nxt  = S_START;
      dly_nxt    = DW'(START_DELAY - 1);
      hold_nxt   = act;
    end
  end

  assign bus.reg_rdata    = src_hi;
  assign bus.dma_active   = act;
  assign bus.dma_read_en  = rd_en;
  assign bus.dma_write_en = wr_en;
  assign bus.dma_addr     = addr;
  assign bus.dma_wdata    = wdata;
endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: elapsed-time transfer model checked every clock, plus directed scenarios.
module tb_oam_dma_controller;
  localparam int NB  = 160;
  localparam int CPB = 4;
  localparam int SD  = 4;

  logic clk;
  logic reset;
  oam_dma_controller_if bus();

  oam_dma_controller #(.NUM_BYTES(NB), .CYCLES_PER_BYTE(CPB), .START_DELAY(SD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  logic [7:0] oam [0:NB-1];
  assign bus.dma_rdata = bus.dma_read_en ? mem[bus.dma_addr] : 8'hFF;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  // reference model: a transfer is just "k clocks since the last write" plus a source base
  bit         m_run  = 1'b0;
  bit         m_hold = 1'b0;
  int         m_k    = 0;
  int         m_base = 0;
  logic [7:0] m_src  = 8'hFF;

  int act_cnt    = 0;
  int strobe_cnt = 0;
  int hi_wr      = 0;

  typedef struct {
    logic [7:0]  src;
    logic [15:0] first;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic monitor_cycle();
    logic [34:0] got, exp, mask;
    logic        e_act, e_rd, e_wr;
    logic [15:0] e_addr;
    logic [7:0]  e_wd;
    bit          addr_care, wd_care;
    int          j, b, ph;
    e_act = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_addr = 16'h0000; e_wd = 8'h00;
    addr_care = 1'b0; wd_care = 1'b0;
    if (!m_run) begin
      addr_care = 1'b1;
      wd_care   = 1'b1;
    end else if (m_k < SD) begin
      e_act = m_hold;
    end else begin
      j  = m_k - SD;
      b  = j / CPB;
      ph = j % CPB;
      e_act = 1'b1;
      addr_care = 1'b1;
      if (ph == 0) begin
        e_rd   = 1'b1;
        e_addr = 16'(m_base + b);
      end else begin
        e_addr = 16'(32'hFE00 + b);
        if (ph == 1) begin
          e_wr    = 1'b1;
          wd_care = 1'b1;
          e_wd    = mem[m_base + b];
        end
      end
    end
    mask = {8'hFF, 3'b111, addr_care ? 16'hFFFF : 16'h0000, wd_care ? 8'hFF : 8'h00};
    exp  = {m_src, e_act, e_rd, e_wr, e_addr, e_wd};
    got  = {bus.reg_rdata, bus.dma_active, bus.dma_read_en, bus.dma_write_en,
            bus.dma_addr, bus.dma_wdata};
    chk("cycle_outputs", 64'(got & mask), 64'(exp & mask));
    if (bus.dma_active === 1'b1) act_cnt++;
    if (bus.dma_read_en === 1'b1 || bus.dma_write_en === 1'b1) strobe_cnt++;
    if (bus.dma_write_en === 1'b1 && bus.dma_addr[15:8] == 8'hFE && bus.dma_addr[7:0] < 8'hA0) begin
      oam[int'(bus.dma_addr[7:0])] = bus.dma_wdata;
      if (bus.dma_addr[7:0] >= 8'h50) hi_wr++;
    end
  endtask

  task automatic model_edge();
    int w;
    if (!reset) begin
      m_run = 1'b0; m_hold = 1'b0; m_k = 0; m_src = 8'hFF;
    end else if (bus.reg_write_en && bus.reg_addr == 16'hFF46) begin
      m_hold = m_run && ((m_k < SD) ? m_hold : 1'b1);
      w      = int'(bus.reg_wdata);
      m_src  = bus.reg_wdata;
      m_base = (w < 224) ? w * 256 : (w - 32) * 256;
      m_k    = 0;
      m_run  = 1'b1;
    end else if (m_run) begin
      m_k++;
      if (m_k >= SD + NB * CPB) m_run = 1'b0;
    end
  endtask

  // check the current cycle at negedge, follow the DUT's sampling edge, return 1 time unit after it
  task automatic tick();
    @(negedge clk);
    if (mon_en) monitor_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reg_write(input logic [7:0] v);
    bus.reg_write_en = 1'b1;
    bus.reg_wdata    = v;
    tick();
    bus.reg_write_en = 1'b0;
  endtask

  task automatic run_to_idle();
    int n = 0;
    while (n < 3000 && (bus.dma_active || m_run)) begin
      tick();
      n++;
    end
    chk("run_to_idle_bound", 64'(n < 3000), 64'd1);
  endtask

  task automatic wait_strobe(input logic [15:0] a, input bit wr);
    int n = 0;
    while (n < 1000 && !((wr ? bus.dma_write_en : bus.dma_read_en) && bus.dma_addr == a)) begin
      tick();
      n++;
    end
    chk("wait_strobe", 64'(n < 1000), 64'd1);
  endtask

  task automatic clear_oam();
    for (int i = 0; i < NB; i++) oam[i] = 8'hxx;
  endtask

  task automatic check_oam(input string name, input int base);
    int bad = 0;
    for (int i = 0; i < NB; i++)
      if (oam[i] !== mem[base + i]) bad++;
    chk(name, 64'(bad), 64'd0);
  endtask

  vec_t vt [8];

  initial begin
    vt[0] = '{8'hC1, 16'hC100};
    vt[1] = '{8'hF0, 16'hD000};
    vt[2] = '{8'hE0, 16'hC000};
    vt[3] = '{8'hDF, 16'hDF00};
    vt[4] = '{8'hFF, 16'hDF00};
    vt[5] = '{8'h00, 16'h0000};
    vt[6] = '{8'h80, 16'h8000};
    vt[7] = '{8'hFE, 16'hDE00};

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < NB; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;

    reset            = 1'b0;
    bus.reg_addr     = 16'hFF46;
    bus.reg_read_en  = 1'b0;
    bus.reg_write_en = 1'b0;
    bus.reg_wdata    = 8'h00;
    tick();
    mon_en = 1'b1;
    ticks(3);
    reset = 1'b1;

    // reset state and a quiet idle period
    chk("reset_rdata", 64'(bus.reg_rdata), 64'hFF);
    chk("reset_active", 64'(bus.dma_active), 64'd0);
    strobe_cnt = 0;
    bus.reg_read_en = 1'b1;
    ticks(100);
    bus.reg_read_en = 1'b0;
    chk("idle_no_strobes", 64'(strobe_cnt), 64'd0);
    chk("idle_rdata", 64'(bus.reg_rdata), 64'hFF);

    // table: full transfers, exact start latency and source base mapping
    for (int v = 0; v < 8; v++) begin
      clear_oam();
      reg_write(vt[v].src);
      act_cnt = 0;
      chk("readback", 64'(bus.reg_rdata), 64'(vt[v].src));
      ticks(SD - 1);
      chk("no_early_read", 64'(bus.dma_read_en), 64'd0);
      tick();
      chk("first_read", 64'({bus.dma_read_en, bus.dma_addr}), 64'({1'b1, vt[v].first}));
      run_to_idle();
      chk("active_len", 64'(act_cnt), 64'(NB * CPB));
      check_oam("oam_copy", int'(vt[v].first));
      if (v == 0) chk("oam_5a_byte", 64'(oam[37]), 64'(8'd37 ^ 8'h5A));
    end

    // restart at idx 50: bus stays owned, copy restarts from C200
    reg_write(8'hC0);
    wait_strobe(16'hC032, 1'b0);
    reg_write(8'hC2);
    act_cnt = 0;
    clear_oam();
    chk("restart_hold_active", 64'(bus.dma_active), 64'd1);
    ticks(SD);
    chk("restart_read", 64'({bus.dma_read_en, bus.dma_addr}), 64'({1'b1, 16'hC200}));
    run_to_idle();
    chk("restart_len", 64'(act_cnt), 64'(SD + NB * CPB));
    check_oam("restart_oam", 16'hC200);

    // reset pulse during the read of idx 80: nothing from FE50 up is written
    reg_write(8'hC1);
    hi_wr = 0;
    wait_strobe(16'hC150, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midreset_active", 64'(bus.dma_active), 64'd0);
    chk("midreset_rdata", 64'(bus.reg_rdata), 64'hFF);
    chk("midreset_strobes", 64'({bus.dma_read_en, bus.dma_write_en}), 64'd0);
    ticks(200);
    chk("midreset_no_hi_writes", 64'(hi_wr), 64'd0);

    // write in the very last WAIT clock: restart without an idle gap
    reg_write(8'hC2);
    wait_strobe(16'hFE9F, 1'b1);
    ticks(CPB - 2);
    reg_write(8'hC3);
    act_cnt = 0;
    clear_oam();
    chk("tail_no_gap", 64'(bus.dma_active), 64'd1);
    ticks(SD);
    chk("tail_read", 64'({bus.dma_read_en, bus.dma_addr}), 64'({1'b1, 16'hC300}));
    run_to_idle();
    chk("tail_len", 64'(act_cnt), 64'(SD + NB * CPB));
    check_oam("tail_oam", 16'hC300);

    // random writes and reset pulses at random times; the per-clock model check covers them
    for (int r = 0; r < 25; r++) begin
      int wait_n;
      wait_n = int'($urandom_range(0, 800));
      for (int i = 0; i < wait_n; i++) begin
        bus.reg_read_en = 1'($urandom_range(0, 1));
        tick();
      end
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end else begin
        reg_write(8'($urandom_range(0, 255)));
      end
    end
    run_to_idle();
    chk("final_rdata", 64'(bus.reg_rdata), 64'(m_src));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
